// File: rtl/vga_ram_pkg.sv
// Shared types for the VGA/CPU RAM arbiter: FSM states, grant
// encoding and default bus widths.
package vga_ram_pkg;

    localparam int DEF_ADDR_W = 24;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        GNT_VGA,
        GNT_CPU
    } gnt_t;

endpackage

// File: rtl/vga_ram_arbiter.sv
// Shares the external RAM port between VGA pixel fetch and the CPU.
// VGA has priority; a streak counter guarantees periodic CPU grants.
module vga_ram_arbiter
    import vga_ram_pkg::*;
#(
    parameter int ADDR_W           = DEF_ADDR_W,
    parameter int DATA_W           = DEF_DATA_W,
    parameter int ACCESS_CYCLES    = 2,
    parameter int CPU_STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int STK_W = $clog2(CPU_STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(CPU_STARVE_LIMIT);

    state_t            state, state_nxt;
    gnt_t              gnt, gnt_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [STK_W-1:0]  streak, streak_nxt;
    logic              cs_nxt, we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              vack_nxt, cack_nxt;
    logic [DATA_W-1:0] vrdata_nxt, crdata_nxt;
    logic              cpu_wins;

    // CPU takes the port when alone, or when VGA has used up its streak
    assign cpu_wins = cpu_req && (!vga_req || streak == STK_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= GNT_VGA;
            cnt       <= '0;
            streak    <= '0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            vga_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            vga_rdata <= '0;
            cpu_rdata <= '0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            cnt       <= cnt_nxt;
            streak    <= streak_nxt;
            ram_cs    <= cs_nxt;
            ram_we    <= we_nxt;
            ram_addr  <= addr_nxt;
            ram_wdata <= wdata_nxt;
            vga_ack   <= vack_nxt;
            cpu_ack   <= cack_nxt;
            vga_rdata <= vrdata_nxt;
            cpu_rdata <= crdata_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        cnt_nxt    = cnt;
        streak_nxt = streak;
        cs_nxt     = ram_cs;
        we_nxt     = ram_we;
        addr_nxt   = ram_addr;
        wdata_nxt  = ram_wdata;
        vack_nxt   = 1'b0;
        cack_nxt   = 1'b0;
        vrdata_nxt = vga_rdata;
        crdata_nxt = cpu_rdata;
        unique case (state)
            IDLE: begin
                if (!cpu_req) streak_nxt = '0;
                if (cpu_wins) begin
                    gnt_nxt    = GNT_CPU;
                    we_nxt     = cpu_we;
                    addr_nxt   = cpu_addr;
                    wdata_nxt  = cpu_wdata;
                    streak_nxt = '0;
                end else if (vga_req) begin
                    gnt_nxt   = GNT_VGA;
                    we_nxt    = 1'b0;
                    addr_nxt  = vga_addr;
                    wdata_nxt = '0;
                    if (cpu_req) streak_nxt = streak + 1'b1;
                end
                if (cpu_req || vga_req) begin
                    cs_nxt    = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    cs_nxt    = 1'b0;
                    we_nxt    = 1'b0;
                    state_nxt = DONE;
                    if (gnt == GNT_CPU) begin
                        cack_nxt = 1'b1;
                        if (!ram_we) crdata_nxt = ram_rdata;
                    end else begin
                        vack_nxt   = 1'b1;
                        vrdata_nxt = ram_rdata;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule
